// File: rtl/image_pkg.sv
// Shared constants and types for the 3x3 window builder.
package image_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int NUM_LINES      = 4;

  // Window geometry: rows are lines (0 = oldest), columns are pixels within a line.
  localparam int WIN_ROWS      = 3;
  localparam int WIN_COLS      = 3;
  localparam int WIN_PIXELS    = WIN_ROWS * WIN_COLS;
  localparam int WIN_WIDTH_DEF = WIN_PIXELS * DATA_WIDTH_DEF;

  typedef enum logic {IDLE, READ} rdState_t;
endpackage

// File: rtl/line_store.sv
// One image line: single write port, registered 3-pixel read (columns p..p+2).
// Read data is valid one cycle after rdEn; there is no flow control.
module line_store
  import image_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_WIDTH  = 512,
  localparam int AW        = $clog2(IMG_WIDTH)
) (
  input  logic                           clk,
  input  logic                           wrEn,
  input  logic [AW-1:0]                  wrAddr,
  input  logic [DATA_WIDTH-1:0]          wrData,
  input  logic                           rdEn,
  input  logic [AW-1:0]                  rdAddr,
  output logic [WIN_COLS*DATA_WIDTH-1:0] rdData
);
  logic [DATA_WIDTH-1:0] mem [IMG_WIDTH];

  // rdAddr never exceeds IMG_WIDTH-3, so rdAddr+2 stays inside the line.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
    if (rdEn) begin
      for (int k = 0; k < WIN_COLS; k++)
        rdData[k*DATA_WIDTH +: DATA_WIDTH] <= mem[rdAddr + AW'(k)];
    end
  end
endmodule

// File: rtl/image_window_ctrl.sv
// Raster pixel stream in, one 3x3 window per cycle out once three lines are buffered.
// Window follows its read by one cycle; no backpressure, pixels arriving while full are dropped.
module image_window_ctrl
  import image_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_WIDTH  = 512
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            inPixel,
  input  logic                             inPixelValid,
  output logic [WIN_PIXELS*DATA_WIDTH-1:0] outWindow,
  output logic                             outWindowValid,
  output logic                             lineDone,
  output logic                             overflow
);
  localparam int AW    = $clog2(IMG_WIDTH);
  localparam int CW    = $clog2(NUM_LINES*IMG_WIDTH + 1);
  localparam int ROW_W = WIN_COLS * DATA_WIDTH;

  localparam logic [CW-1:0] FULL_CNT  = CW'(NUM_LINES * IMG_WIDTH);
  localparam logic [CW-1:0] START_CNT = CW'(WIN_ROWS * IMG_WIDTH);
  localparam logic [CW-1:0] LINE_CNT  = CW'(IMG_WIDTH);
  localparam logic [AW-1:0] LAST_WR   = AW'(IMG_WIDTH - 1);
  localparam logic [AW-1:0] LAST_RD   = AW'(IMG_WIDTH - WIN_COLS);

  logic [AW-1:0]    wrPtr, rdPtr;
  logic [1:0]       wrLine, rdLine, rdLineQ;
  logic [CW-1:0]    fillCount;
  rdState_t         state, stateNext;
  logic             full, wrEn, rdEn, retire, readStart;
  logic [ROW_W-1:0] rowData [NUM_LINES];

  assign full      = (fillCount == FULL_CNT);
  assign wrEn      = inPixelValid && !full;
  assign readStart = (fillCount >= START_CNT);
  assign rdEn      = (state == READ);
  assign retire    = rdEn && (rdPtr == LAST_RD);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (readStart) stateNext = READ;
      READ:    if (retire)    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wrPtr          <= '0;
      wrLine         <= '0;
      rdPtr          <= '0;
      rdLine         <= '0;
      rdLineQ        <= '0;
      fillCount      <= '0;
      outWindowValid <= 1'b0;
      lineDone       <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      state <= stateNext;
      if (wrEn) begin
        if (wrPtr == LAST_WR) begin
          wrPtr  <= '0;
          wrLine <= wrLine + 2'd1;
        end else begin
          wrPtr <= wrPtr + 1'b1;
        end
      end
      // rdLineQ tracks the line base of the read now in flight, since rdLine advances on retire.
      if (rdEn) begin
        rdLineQ <= rdLine;
        if (retire) begin
          rdPtr  <= '0;
          rdLine <= rdLine + 2'd1;
        end else begin
          rdPtr <= rdPtr + 1'b1;
        end
      end
      fillCount      <= fillCount + CW'(wrEn) - (retire ? LINE_CNT : '0);
      outWindowValid <= rdEn;
      lineDone       <= retire;
      if (inPixelValid && full) overflow <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LINES; i++) begin : gLine
    line_store #(
      .DATA_WIDTH(DATA_WIDTH),
      .IMG_WIDTH (IMG_WIDTH)
    ) uStore (
      .clk   (clk),
      .wrEn  (wrEn && (wrLine == 2'(i))),
      .wrAddr(wrPtr),
      .wrData(inPixel),
      .rdEn  (rdEn),
      .rdAddr(rdPtr),
      .rdData(rowData[i])
    );
  end

  // Rotate physical lines so row 0 is always the oldest line of the window.
  always_comb begin
    outWindow = '0;
    if (outWindowValid) begin
      for (int r = 0; r < WIN_ROWS; r++)
        outWindow[r*ROW_W +: ROW_W] = rowData[rdLineQ + 2'(r)];
    end
  end
endmodule

// File: tb/tb_image_window_ctrl.sv
// Directed bench for image_window_ctrl with 8-pixel lines; pixel value = 16*line + column.
module tb_image_window_ctrl;
  localparam int DW = 8;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] inPixel = '0;
  logic          inPixelValid = 1'b0;
  logic [9*DW-1:0] outWindow;
  logic          outWindowValid, lineDone, overflow;

  image_window_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(IW)) dut (
    .clk           (clk),
    .rst           (rst),
    .inPixel       (inPixel),
    .inPixelValid  (inPixelValid),
    .outWindow     (outWindow),
    .outWindowValid(outWindowValid),
    .lineDone      (lineDone),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  int lastAccept = 0;
  logic [9*DW-1:0] winQ [$];
  int winCyc [$];
  int doneCyc [$];

  task automatic checkVal(input string tag, input logic [71:0] got, input logic [71:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of input, then sample outputs just after the edge.
  task automatic tick(input logic v, input logic [DW-1:0] p);
    inPixelValid = v;
    inPixel      = p;
    @(posedge clk);
    #1;
    cyc++;
    if (outWindowValid) begin
      winQ.push_back(outWindow);
      winCyc.push_back(cyc);
    end
    if (lineDone) doneCyc.push_back(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0);
  endtask

  task automatic sendLines(input int first, input int n);
    for (int l = first; l < first + n; l++)
      for (int c = 0; c < IW; c++) begin
        tick(1'b1, 8'(16*l + c));
        lastAccept = cyc;
      end
    inPixelValid = 1'b0;
  endtask

  task automatic clearLog();
    winQ.delete();
    winCyc.delete();
    doneCyc.delete();
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    clearLog();
  endtask

  function automatic logic [71:0] expWin(input int base, input int col);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        w[8*(3*r+k) +: 8] = 8'(16*(base+r) + col + k);
    return w;
  endfunction

  initial begin
    // Reset state
    doReset();
    checkVal("rst_outWindow", outWindow, 72'h0);
    checkVal("rst_valid", outWindowValid, 0);
    checkVal("rst_lineDone", lineDone, 0);
    checkVal("rst_overflow", overflow, 0);
    checkVal("rst_fill", dut.fillCount, 0);

    // Three lines back to back
    sendLines(0, 3);
    checkVal("s1_fill24", dut.fillCount, 24);
    idle(12);
    checkVal("s1_count", winQ.size(), 6);
    if (winQ.size() == 6) begin
      checkVal("s1_latency", winCyc[0] - lastAccept, 2);
      checkVal("s1_contig", winCyc[5] - winCyc[0], 5);
      for (int c = 0; c < 6; c++)
        checkVal($sformatf("s1_win%0d", c), winQ[c], expWin(0, c));
      checkVal("s1_first_rows", winQ[0], 72'h22_21_20_12_11_10_02_01_00);
      checkVal("s1_done_n", doneCyc.size(), 1);
      if (doneCyc.size() == 1) checkVal("s1_done_cyc", doneCyc[0], winCyc[5]);
    end
    checkVal("s1_fill16", dut.fillCount, 16);

    // Two lines only: no window
    doReset();
    sendLines(0, 2);
    idle(12);
    checkVal("s2_count", winQ.size(), 0);
    checkVal("s2_fill", dut.fillCount, 16);

    // Six lines continuously, crossing the line-index wrap
    doReset();
    sendLines(0, 6);
    idle(20);
    checkVal("s3_count", winQ.size(), 24);
    if (winQ.size() == 24)
      for (int g = 0; g < 4; g++)
        for (int c = 0; c < 6; c++)
          checkVal($sformatf("s3_g%0d_w%0d", g, c), winQ[6*g+c], expWin(g, c));
    checkVal("s3_done_n", doneCyc.size(), 4);
    checkVal("s3_overflow", overflow, 0);
    checkVal("s3_fill", dut.fillCount, 16);

    // Five lines with the reader held off: storage fills, extra pixels dropped
    doReset();
    force dut.readStart = 1'b0;
    sendLines(0, 5);
    idle(2);
    checkVal("s4_overflow", overflow, 1);
    checkVal("s4_fill_full", dut.fillCount, 32);
    checkVal("s4_no_win", winQ.size(), 0);
    release dut.readStart;
    idle(30);
    checkVal("s4_count", winQ.size(), 12);
    if (winQ.size() == 12) begin
      checkVal("s4_g0_w0", winQ[0], expWin(0, 0));
      checkVal("s4_g1_w0", winQ[6], expWin(1, 0));
      checkVal("s4_g1_w5", winQ[11], expWin(1, 5));
    end
    checkVal("s4_overflow_sticky", overflow, 1);
    checkVal("s4_fill_end", dut.fillCount, 16);

    // Reset in the middle of a READ burst
    doReset();
    sendLines(0, 3);
    idle(3);
    checkVal("s5_mid_read", winQ.size(), 2);
    rst = 1'b1;
    tick(1'b0, '0);
    checkVal("s5_rst_valid", outWindowValid, 0);
    checkVal("s5_rst_window", outWindow, 72'h0);
    checkVal("s5_rst_done", lineDone, 0);
    rst = 1'b0;
    tick(1'b0, '0);
    checkVal("s5_post_valid", outWindowValid, 0);
    checkVal("s5_post_fill", dut.fillCount, 0);
    clearLog();
    sendLines(0, 3);
    idle(12);
    checkVal("s5_count", winQ.size(), 6);
    if (winQ.size() == 6) begin
      checkVal("s5_latency", winCyc[0] - lastAccept, 2);
      for (int c = 0; c < 6; c++)
        checkVal($sformatf("s5_win%0d", c), winQ[c], expWin(0, c));
    end

    // Pixel accepted on the same edge a line retires
    doReset();
    sendLines(0, 3);
    idle(6);
    checkVal("s6_pre_fill", dut.fillCount, 24);
    tick(1'b1, 8'h30);
    checkVal("s6_lineDone", lineDone, 1);
    checkVal("s6_fill", dut.fillCount, 17);
    checkVal("s6_overflow", overflow, 0);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
